cyclotron_trace_queue: RTL and testbench
========================================

Name: cyclotron_trace_queue

Overview:
Multi-port, parametrised writeback-trace buffer sitting between the core's register-writeback trace taps and the Cyclotron difftest checker. Accepts up to NUM_PORTS trace records per cycle, one per retiring lane-group, and compacts them in port order into a DEPTH-entry FIFO. It drains one record per cycle over a valid/ready interface, so the checker sees a single ordered stream regardless of core issue width. Applies lane-mask and x0 sanitising at enqueue; flags overflow instead of silently losing trace.

Parameters:
ARCH_LEN, 32, register/PC width
NUM_LANES, 16, lanes per record
NUM_WARPS, 8, warps; WARP_ID_BITS = $clog2(NUM_WARPS)
REG_BITS, 8, register address width
NUM_REGS, 3, register writes per record
NUM_PORTS, 2, input trace ports per cycle
DEPTH, 16, FIFO entries; power of two, >= 2*NUM_PORTS
CNT_BITS, 32, statistics counter width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  discard all queued records
in_valid  in  NUM_PORTS  per-port record valid
in_ready  out  1  all ports may enqueue this cycle
in_pc  in  NUM_PORTS*ARCH_LEN  per-port PC
in_warpId  in  NUM_PORTS*WARP_ID_BITS  per-port warp
in_tmask  in  NUM_PORTS*NUM_LANES  per-port thread mask
in_reg_en  in  NUM_PORTS*NUM_REGS  write enables
in_reg_addr  in  NUM_PORTS*NUM_REGS*REG_BITS  write addresses
in_reg_data  in  NUM_PORTS*NUM_REGS*NUM_LANES*ARCH_LEN  write data, lane 0 in LSBs
out_valid  out  1  head record valid
out_ready  in  1  checker consumes head
out_pc / out_warpId / out_tmask / out_reg_en / out_reg_addr / out_reg_data  out  single-record widths  head record fields
occupancy  out  $clog2(DEPTH+1)  queued record count
overflow  out  1  sticky: a valid record was dropped
stat_enq  out  CNT_BITS  records enqueued
stat_drop  out  CNT_BITS  records dropped
stat_stall  out  CNT_BITS  cycles out_valid && !out_ready

Behaviour:
- Reset (sync, high): rd/wr pointers 0, occupancy 0, out_valid 0, overflow 0, all stat_* 0, output fields 0.
- in_ready = (DEPTH - occupancy) >= NUM_PORTS, from registered occupancy only; same-cycle dequeue does not raise it.
- Enqueue when in_ready: valid ports written in ascending port index to consecutive slots from wr_ptr; invalid ports take no slot (compaction). wr_ptr += popcount(in_valid), modulo DEPTH.
- Any in_valid bit while !in_ready: all records that cycle dropped (no partial enqueue), overflow set, stat_drop += popcount(in_valid).
- Sanitising at enqueue: lanes with tmask bit 0 stored as 0 data in every reg slot; reg slot with addr 0 has en forced 0 and data stored 0.
- Show-ahead: out_valid = occupancy != 0; out_* driven from mem[rd_ptr] (zero when empty). Record enqueued in cycle N visible at earliest cycle N+1.
- Dequeue when out_valid && out_ready: rd_ptr += 1 mod DEPTH. out_ready while empty is ignored.
- Simultaneous enqueue k and dequeue: occupancy_next = occupancy + k - 1.
- flush: pointers and occupancy to 0 next cycle; overrides same-cycle enqueue and dequeue (those records neither counted nor dropped); overflow and stats retained.
- Reset mid-stream: all queued records discarded, state as at reset.
- Storage: flat register array; no X-propagation from unwritten slots to out_* (zero-initialised at reset).

Optional Feature:
CYCLOTRON_TRACE_STATS_EN: defined -> stat_enq, stat_drop, stat_stall count as above, saturating at all-ones, cleared only by reset. Undefined -> the three stat ports tied 0 and counters not instantiated; overflow and all other behaviour unchanged.

Test Plan:
- Reset, then in_valid=2'b11, pc0=0x100, pc1=0x104, out_ready=1 -> cycle+1 out_pc=0x100, cycle+2 out_pc=0x104, occupancy returns 0; stat_enq=2.
- in_valid=2'b10, pc1=0x200 -> single record 0x200 at head, occupancy=1 (compaction, no hole).
- out_ready=0, push 2 records/cycle for 8 cycles (DEPTH=16) -> in_ready=0 at occupancy 16; 9th push with in_valid=2'b11 -> overflow=1, stat_drop=2, occupancy stays 16; stat_stall increments each stalled cycle.
- tmask=0x0001, reg0 addr=5 data all lanes 0xDEADBEEF, reg1 addr=0 en=1 -> out lane0 0xDEADBEEF, lanes1-15 0, out_reg_en[1]=0.
- Occupancy 4, flush with in_valid=2'b11 and out_ready=1 same cycle -> occupancy 0 next cycle, out_valid=0, stat_enq unchanged, overflow unchanged.
- Run 40 records through with random out_ready -> exact ordered match against scoreboard across pointer wrap-around.

Source files
------------

// File: rtl/cyclotron_trace_queue.sv
// cyclotron_trace_queue: multi-port writeback-trace buffer feeding the Cyclotron
// difftest checker. Valid records from up to NUM_PORTS ports are compacted in port
// order into a DEPTH-entry FIFO and drained one per cycle, show-ahead.
// Optional feature macro: CYCLOTRON_TRACE_STATS_EN enables the saturating
// stat_enq / stat_drop / stat_stall counters; otherwise they read 0.
module cyclotron_trace_queue #(
    parameter int ARCH_LEN  = 32,
    parameter int NUM_LANES = 16,
    parameter int NUM_WARPS = 8,
    parameter int REG_BITS  = 8,
    parameter int NUM_REGS  = 3,
    parameter int NUM_PORTS = 2,
    parameter int DEPTH     = 16,
    parameter int CNT_BITS  = 32,
    localparam int WARP_ID_BITS = $clog2(NUM_WARPS),
    localparam int OCC_BITS     = $clog2(DEPTH + 1),
    localparam int DATA_W       = NUM_REGS * NUM_LANES * ARCH_LEN
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic [NUM_PORTS-1:0]                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_PORTS*ARCH_LEN-1:0]         in_pc,
    input  logic [NUM_PORTS*WARP_ID_BITS-1:0]     in_warpId,
    input  logic [NUM_PORTS*NUM_LANES-1:0]        in_tmask,
    input  logic [NUM_PORTS*NUM_REGS-1:0]         in_reg_en,
    input  logic [NUM_PORTS*NUM_REGS*REG_BITS-1:0] in_reg_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]           in_reg_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ARCH_LEN-1:0]                   out_pc,
    output logic [WARP_ID_BITS-1:0]               out_warpId,
    output logic [NUM_LANES-1:0]                  out_tmask,
    output logic [NUM_REGS-1:0]                   out_reg_en,
    output logic [NUM_REGS*REG_BITS-1:0]          out_reg_addr,
    output logic [DATA_W-1:0]                     out_reg_data,
    output logic [OCC_BITS-1:0]                   occupancy,
    output logic                                  overflow,
    output logic [CNT_BITS-1:0]                   stat_enq,
    output logic [CNT_BITS-1:0]                   stat_drop,
    output logic [CNT_BITS-1:0]                   stat_stall
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [OCC_BITS-1:0] OCC_LIMIT = OCC_BITS'(DEPTH - NUM_PORTS);

    logic [ARCH_LEN-1:0]          r_pc    [DEPTH];
    logic [WARP_ID_BITS-1:0]      r_wid   [DEPTH];
    logic [NUM_LANES-1:0]         r_tmask [DEPTH];
    logic [NUM_REGS-1:0]          r_en    [DEPTH];
    logic [NUM_REGS*REG_BITS-1:0] r_addr  [DEPTH];
    logic [DATA_W-1:0]            r_data  [DEPTH];
    logic [PTR_BITS-1:0]          r_rd_ptr, r_wr_ptr;
    logic [OCC_BITS-1:0]          r_occ;
    logic                         r_overflow;

    logic [OCC_BITS-1:0]                      w_k;
    logic [NUM_PORTS-1:0][PTR_BITS-1:0]       w_slot;
    logic [NUM_PORTS-1:0][DATA_W-1:0]         w_san_data;
    logic [NUM_PORTS-1:0][NUM_REGS-1:0]       w_san_en;
    logic                                     w_any, w_enq, w_drop, w_deq;

    // in_ready looks only at registered occupancy, so a same-cycle pop never helps.
    assign in_ready  = (r_occ <= OCC_LIMIT);
    assign out_valid = (r_occ != '0);
    assign w_any     = |in_valid;
    assign w_enq     = w_any && in_ready && !flush;
    assign w_drop    = w_any && !in_ready && !flush;
    assign w_deq     = out_valid && out_ready && !flush;
    assign occupancy = r_occ;
    assign overflow  = r_overflow;

    // Compaction: each valid port lands at wr_ptr + (valid ports below it).
    always_comb begin
        w_k    = '0;
        w_slot = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_slot[p] = r_wr_ptr + PTR_BITS'(w_k);
            w_k       = w_k + OCC_BITS'(in_valid[p]);
        end
    end

    // Sanitising: inactive lanes and writes to x0 are stored as zero / disabled.
    always_comb begin
        w_san_data = '0;
        w_san_en   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                w_san_en[p][r] = in_reg_en[p*NUM_REGS+r] &&
                                 (in_reg_addr[(p*NUM_REGS+r)*REG_BITS +: REG_BITS] != '0);
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (in_tmask[p*NUM_LANES+l] &&
                        (in_reg_addr[(p*NUM_REGS+r)*REG_BITS +: REG_BITS] != '0))
                        w_san_data[p][(r*NUM_LANES+l)*ARCH_LEN +: ARCH_LEN] =
                            in_reg_data[p*DATA_W + (r*NUM_LANES+l)*ARCH_LEN +: ARCH_LEN];
                end
            end
        end
    end

    // FIFO storage, pointers, occupancy and sticky overflow; flush beats enq/deq.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_wid[i]   <= '0;
                r_tmask[i] <= '0;
                r_en[i]    <= '0;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_enq) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (in_valid[p]) begin
                        r_pc[w_slot[p]]    <= in_pc[p*ARCH_LEN +: ARCH_LEN];
                        r_wid[w_slot[p]]   <= in_warpId[p*WARP_ID_BITS +: WARP_ID_BITS];
                        r_tmask[w_slot[p]] <= in_tmask[p*NUM_LANES +: NUM_LANES];
                        r_en[w_slot[p]]    <= w_san_en[p];
                        r_addr[w_slot[p]]  <= in_reg_addr[p*NUM_REGS*REG_BITS +: NUM_REGS*REG_BITS];
                        r_data[w_slot[p]]  <= w_san_data[p];
                    end
                end
                r_wr_ptr <= r_wr_ptr + PTR_BITS'(w_k);
            end
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            r_occ <= r_occ + (w_enq ? w_k : '0) - OCC_BITS'(w_deq);
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // Show-ahead head; fields forced to zero while empty.
    assign out_pc       = out_valid ? r_pc[r_rd_ptr]    : '0;
    assign out_warpId   = out_valid ? r_wid[r_rd_ptr]   : '0;
    assign out_tmask    = out_valid ? r_tmask[r_rd_ptr] : '0;
    assign out_reg_en   = out_valid ? r_en[r_rd_ptr]    : '0;
    assign out_reg_addr = out_valid ? r_addr[r_rd_ptr]  : '0;
    assign out_reg_data = out_valid ? r_data[r_rd_ptr]  : '0;

`ifdef CYCLOTRON_TRACE_STATS_EN
    logic [CNT_BITS-1:0] r_stat_enq, r_stat_drop, r_stat_stall;
    logic [CNT_BITS:0]   w_enq_sum, w_drop_sum;

    assign w_enq_sum  = {1'b0, r_stat_enq}  + (CNT_BITS+1)'(w_k);
    assign w_drop_sum = {1'b0, r_stat_drop} + (CNT_BITS+1)'(w_k);

    // Saturating statistics; flush does not clear them.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_enq   <= '0;
            r_stat_drop  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_enq)
                r_stat_enq <= w_enq_sum[CNT_BITS] ? '1 : w_enq_sum[CNT_BITS-1:0];
            if (w_drop)
                r_stat_drop <= w_drop_sum[CNT_BITS] ? '1 : w_drop_sum[CNT_BITS-1:0];
            if (out_valid && !out_ready && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + CNT_BITS'(1);
        end
    end

    assign stat_enq   = r_stat_enq;
    assign stat_drop  = r_stat_drop;
    assign stat_stall = r_stat_stall;
`else
    assign stat_enq   = '0;
    assign stat_drop  = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_cyclotron_trace_queue.sv
// Scoreboard bench for cyclotron_trace_queue: stimulus pushes expected records,
// a negedge monitor pops and compares on every consumed head record.
module tb_cyclotron_trace_queue;
    localparam int DW = 3 * 16 * 32;
`ifdef CYCLOTRON_TRACE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clock = 1'b0, reset = 1'b1, flush = 1'b0, out_ready = 1'b0;
    logic [1:0]      in_valid = '0;
    logic            in_ready, out_valid, overflow;
    logic [63:0]     in_pc = '0;
    logic [5:0]      in_warpId = '0;
    logic [31:0]     in_tmask = '0;
    logic [5:0]      in_reg_en = '0;
    logic [47:0]     in_reg_addr = '0;
    logic [2*DW-1:0] in_reg_data = '0;
    logic [31:0]     out_pc;
    logic [2:0]      out_warpId;
    logic [15:0]     out_tmask;
    logic [2:0]      out_reg_en;
    logic [23:0]     out_reg_addr;
    logic [DW-1:0]   out_reg_data;
    logic [4:0]      occupancy;
    logic [31:0]     stat_enq, stat_drop, stat_stall;

    cyclotron_trace_queue dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_warpId(in_warpId), .in_tmask(in_tmask),
        .in_reg_en(in_reg_en), .in_reg_addr(in_reg_addr), .in_reg_data(in_reg_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_warpId(out_warpId), .out_tmask(out_tmask),
        .out_reg_en(out_reg_en), .out_reg_addr(out_reg_addr), .out_reg_data(out_reg_data),
        .occupancy(occupancy), .overflow(overflow),
        .stat_enq(stat_enq), .stat_drop(stat_drop), .stat_stall(stat_stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]   pc;
        logic [2:0]    wid;
        logic [15:0]   tmask;
        logic [2:0]    en;
        logic [23:0]   addr;
        logic [DW-1:0] data;
    } rec_t;

    rec_t sb[$];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] st(input int v);
        return STATS ? 64'(v) : 64'd0;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [31:0] seed);
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = seed ^ (32'(i) * 32'h01010101);
        return d;
    endfunction

    function automatic rec_t mk(input logic [31:0] pc, input logic [2:0] wid,
                                input logic [15:0] tm, input logic [2:0] en,
                                input logic [23:0] addr, input logic [DW-1:0] data);
        rec_t r;
        r.pc = pc; r.wid = wid; r.tmask = tm; r.en = en; r.addr = addr; r.data = data;
        return r;
    endfunction

    task automatic drive(input int p, input rec_t r);
        in_pc[p*32 +: 32]       = r.pc;
        in_warpId[p*3 +: 3]     = r.wid;
        in_tmask[p*16 +: 16]    = r.tmask;
        in_reg_en[p*3 +: 3]     = r.en;
        in_reg_addr[p*24 +: 24] = r.addr;
        in_reg_data[p*DW +: DW] = r.data;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every consumed head record must match the scoreboard front.
    always @(negedge clock) begin
        rec_t e;
        if (!reset && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_out: pc 0x%0h with empty scoreboard", out_pc);
            end else begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_warpId", out_warpId, e.wid);
                chk("out_tmask", out_tmask, e.tmask);
                chk("out_reg_en", out_reg_en, e.en);
                chk("out_reg_addr", out_reg_addr, e.addr);
                n_cmp++;
                if (out_reg_data !== e.data) begin
                    n_bad++;
                    for (int w = 0; w < DW/32; w++)
                        if (out_reg_data[w*32 +: 32] !== e.data[w*32 +: 32]) begin
                            $display("FAIL out_reg_data pc 0x%0h word %0d: got 0x%0h expected 0x%0h",
                                     e.pc, w, out_reg_data[w*32 +: 32], e.data[w*32 +: 32]);
                            break;
                        end
                end
            end
        end
    end

    initial begin
        rec_t r0, r1, e;
        logic [DW-1:0] raw, d;
        int sent, cyc;
        logic [1:0] v;
        logic model_rdy;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_stat_enq", stat_enq, 0);
        tick();

        // Two records in one cycle, drained in port order
        r0 = mk(32'h100, 3'd1, 16'hFFFF, 3'b111, {8'd3, 8'd2, 8'd1}, pat(32'h100));
        r1 = mk(32'h104, 3'd2, 16'hFFFF, 3'b101, {8'd6, 8'd5, 8'd4}, pat(32'h104));
        drive(0, r0); drive(1, r1); in_valid = 2'b11; out_ready = 1'b1;
        sb.push_back(r0); sb.push_back(r1);
        tick(); in_valid = '0;
        chk("t1_head0_pc", out_pc, 32'h100);
        chk("t1_occ2", occupancy, 2);
        tick();
        chk("t1_head1_pc", out_pc, 32'h104);
        tick();
        chk("t1_occ0", occupancy, 0);
        chk("t1_stat_enq", stat_enq, st(2));
        out_ready = 1'b0;

        // Compaction: only port 1 valid
        r1 = mk(32'h200, 3'd7, 16'hFFFF, 3'b010, {8'd9, 8'd8, 8'd7}, pat(32'h200));
        drive(1, r1); in_valid = 2'b10; sb.push_back(r1);
        tick(); in_valid = '0;
        chk("t2_occ1", occupancy, 1);
        chk("t2_head_pc", out_pc, 32'h200);
        chk("t2_out_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Fill to DEPTH with a stalled consumer, then overflow
        for (int i = 0; i < 8; i++) begin
            r0 = mk(32'h300 + 32'(8*i), 3'(i), 16'hFFFF, 3'b111, {8'd1, 8'd2, 8'd3}, pat(32'h300 + 32'(i)));
            r1 = mk(32'h304 + 32'(8*i), 3'(i+1), 16'hFFFF, 3'b011, {8'd4, 8'd5, 8'd6}, pat(32'h380 + 32'(i)));
            drive(0, r0); drive(1, r1); in_valid = 2'b11;
            sb.push_back(r0); sb.push_back(r1);
            tick();
            if (i == 6) chk("t3_in_ready_occ14", in_ready, 1);
        end
        chk("t3_occ16", occupancy, 16);
        chk("t3_in_ready0", in_ready, 0);
        chk("t3_stall7", stat_stall, st(7));
        chk("t3_no_ovf_yet", overflow, 0);
        r0 = mk(32'h3F0, 3'd0, 16'hFFFF, 3'b111, {8'd1, 8'd1, 8'd1}, pat(32'h3F0));
        drive(0, r0); drive(1, r0); in_valid = 2'b11;
        tick(); in_valid = '0;
        chk("t3_overflow", overflow, 1);
        chk("t3_occ_stays16", occupancy, 16);
        chk("t3_stat_drop", stat_drop, st(2));
        chk("t3_stall8", stat_stall, st(8));
        chk("t3_stat_enq", stat_enq, st(19));
        out_ready = 1'b1;
        repeat (16) tick();
        chk("t3_drained", occupancy, 0);
        out_ready = 1'b0;

        // Sanitising: lane mask and x0 writes
        raw = '0;
        for (int l = 0; l < 16; l++) begin
            raw[(0*16 + l)*32 +: 32] = 32'hDEADBEEF;
            raw[(1*16 + l)*32 +: 32] = 32'h12345678;
            raw[(2*16 + l)*32 +: 32] = 32'hA5A5A5A5;
        end
        r0 = mk(32'h500, 3'd3, 16'h0001, 3'b011, {8'd7, 8'd0, 8'd5}, raw);
        drive(0, r0); in_valid = 2'b01;
        d = '0;
        d[31:0] = 32'hDEADBEEF;
        d[(2*16)*32 +: 32] = 32'hA5A5A5A5;
        e = mk(32'h500, 3'd3, 16'h0001, 3'b001, {8'd7, 8'd0, 8'd5}, d);
        sb.push_back(e);
        tick(); in_valid = '0;
        chk("t4_lane0", out_reg_data[31:0], 32'hDEADBEEF);
        chk("t4_lane1_zero", out_reg_data[63:32], 0);
        chk("t4_reg1_en0", out_reg_en[1], 0);
        chk("t4_reg1_data0", out_reg_data[16*32 +: 32], 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush overrides same-cycle enqueue and dequeue
        for (int i = 0; i < 2; i++) begin
            r0 = mk(32'h600 + 32'(8*i), 3'd4, 16'hFFFF, 3'b001, {8'd1, 8'd1, 8'd1}, pat(32'h600 + 32'(i)));
            r1 = mk(32'h604 + 32'(8*i), 3'd5, 16'hFFFF, 3'b001, {8'd1, 8'd1, 8'd1}, pat(32'h680 + 32'(i)));
            drive(0, r0); drive(1, r1); in_valid = 2'b11;
            sb.push_back(r0); sb.push_back(r1);
            tick();
        end
        chk("t5_occ4", occupancy, 4);
        flush = 1'b1; out_ready = 1'b1; in_valid = 2'b11;
        tick();
        flush = 1'b0; in_valid = '0; out_ready = 1'b0;
        sb.delete();
        chk("t5_occ0", occupancy, 0);
        chk("t5_out_valid0", out_valid, 0);
        chk("t5_out_pc0", out_pc, 0);
        chk("t5_stat_enq", stat_enq, st(24));
        chk("t5_overflow_kept", overflow, 1);
        chk("t5_stall9", stat_stall, st(9));

        // 40 records with random back-pressure across pointer wrap
        sent = 0; cyc = 0;
        while ((sent < 40 || sb.size() != 0) && cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            model_rdy = (16 - sb.size()) >= 2;
            chk("rand_in_ready", in_ready, model_rdy);
            chk("rand_occ", occupancy, sb.size());
            if (sent < 40 && model_rdy) begin
                v = 2'($urandom_range(0, 3));
                if (40 - sent == 1 && v == 2'b11) v = 2'b10;
                in_valid = v;
                for (int p = 0; p < 2; p++)
                    if (v[p]) begin
                        r0 = mk(32'h1000 + 32'(4*sent), 3'($urandom), 16'hFFFF, 3'($urandom),
                                {8'd9, 8'd8, 8'd7}, pat($urandom));
                        drive(p, r0);
                        sb.push_back(r0);
                        sent++;
                    end
            end else begin
                in_valid = '0;
            end
            tick();
            cyc++;
        end
        in_valid = '0;
        chk("rand_completed", (sent == 40 && sb.size() == 0), 1);
        chk("rand_stat_enq", stat_enq, st(64));
        chk("final_overflow", overflow, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
